// File: rtl/tub_scan_driver.sv
// tub_scan_driver: multiplexed tube scanner with shadow/active buffers and frame-boundary commit; blink option via TUB_SCAN_BLINK_EN
module tub_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_digit,
  input  logic [7:0] wr_seg,
  input  logic       wr_commit,
  input  logic [7:0] digit_en,
`ifdef TUB_SCAN_BLINK_EN
  input  logic [7:0] blink_mask,
`endif
  output logic [7:0] tub_sel,
  output logic [7:0] tub_control,
  output logic       frame_done
);
  localparam int CW = $clog2((CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] SHOW_N  = CW'(CLK_DIV);
  localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [2:0]    LAST    = 3'(DIGITS - 1);
  localparam logic [3:0]    NDIG    = 4'(DIGITS);
  typedef enum logic [1:0] {SHOW, BLANK, SWAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] d, d_n;
  logic pending, swap, lit, fd_n;
  logic [7:0] nxt_seg;
  logic [7:0] shadow [8];
  logic [7:0] active [8];
  assign wr_ready = rst | ~pending;
  // cnt holds the number of cycles already spent in the state, so reset (cnt=0 in SHOW) gives digit 0 a full slot
  always_comb begin
    state_n = state;
    cnt_n   = cnt + ONE;
    d_n     = d;
    swap    = 1'b0;
    if (state == SHOW && cnt == SHOW_N) begin
      state_n = BLANK;
      cnt_n   = ONE;
    end else if (state == BLANK && cnt == BLANK_N) begin
      state_n = (d == LAST && pending) ? SWAP : SHOW;
      cnt_n   = ONE;
      d_n     = (d == LAST) ? '0 : d + 3'd1;
    end else if (state == SWAP) begin
      state_n = SHOW;
      cnt_n   = ONE;
      d_n     = '0;
      swap    = 1'b1;
    end
  end
  assign fd_n    = state_n == BLANK && cnt_n == BLANK_N && d_n == LAST;
  assign nxt_seg = swap ? shadow[d_n] : active[d_n];
`ifdef TUB_SCAN_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge clk)
    if (rst) frame_cnt <= '0;
    else if (fd_n) frame_cnt <= frame_cnt + 6'd1;
  assign lit = state_n == SHOW && digit_en[d_n] && !(frame_cnt[5] && blink_mask[d_n]);
`else
  assign lit = state_n == SHOW && digit_en[d_n];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW;
      cnt         <= '0;
      d           <= '0;
      pending     <= 1'b0;
      tub_sel     <= '0;
      tub_control <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      d           <= d_n;
      pending     <= swap ? 1'b0 : (pending | wr_commit);
      tub_sel     <= lit ? 8'b1 << d_n : '0;
      tub_control <= lit ? nxt_seg : '0;
      frame_done  <= fd_n;
    end
  end
  // active only changes on the SWAP exit edge, when every tube has been dark for a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (swap)
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      if (wr_valid && !pending && {1'b0, wr_digit} < NDIG) shadow[wr_digit] <= wr_seg;
    end
  end
endmodule

// File: tb/tb_tub_scan_driver.sv
// tb_tub_scan_driver: scoreboard bench for 8-digit and 4-digit scanners against a frame-position model
module tb_tub_scan_driver;
  localparam int CD = 4, BC = 2, P = CD + BC;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, wr_commit = 1'b0;
  logic [2:0] wr_digit = '0;
  logic [7:0] wr_seg = '0, digit_en = 8'hFF;
  logic [7:0] sel [2];
  logic [7:0] ctl [2];
  logic fd [2];
  logic rdy [2];
  typedef struct packed {logic [7:0] sel; logic [7:0] ctl; logic fd; logic rdy;} exp_t;
  exp_t q [2][$];
  int t [2];
  bit pend [2];
  logic [7:0] sh [2][8];
  logic [7:0] ac [2][8];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  tub_scan_driver #(.DIGITS(8), .CLK_DIV(CD), .BLANK_CYCLES(BC)) u8 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[0]), .wr_digit(wr_digit),
    .wr_seg(wr_seg), .wr_commit(wr_commit), .digit_en(digit_en),
    .tub_sel(sel[0]), .tub_control(ctl[0]), .frame_done(fd[0]));
  tub_scan_driver #(.DIGITS(4), .CLK_DIV(CD), .BLANK_CYCLES(BC)) u4 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[1]), .wr_digit(wr_digit),
    .wr_seg(wr_seg), .wr_commit(wr_commit), .digit_en(digit_en),
    .tub_sel(sel[1]), .tub_control(ctl[1]), .frame_done(fd[1]));
  // model: t is the position of the upcoming cycle inside the frame; t == nd*P is the swap cycle
  initial begin
    int nd, fl, s;
    bit p;
    exp_t e;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        nd = (k == 0) ? 8 : 4;
        fl = nd * P;
        e = '0;
        if (rst) begin
          t[k] = -1;
          pend[k] = 1'b0;
          for (int i = 0; i < 8; i++) begin
            sh[k][i] = '0;
            ac[k][i] = '0;
          end
          e.rdy = 1'b1;
        end else begin
          p = pend[k];
          if (t[k] == fl) begin
            t[k] = 0;
            for (int i = 0; i < 8; i++) ac[k][i] = sh[k][i];
            pend[k] = 1'b0;
          end else if (t[k] == fl - 1 && p) t[k] = fl;
          else t[k] = (t[k] + 1) % fl;
          if (wr_valid && !p && int'(wr_digit) < nd) sh[k][wr_digit] = wr_seg;
          if (wr_commit && !p) pend[k] = 1'b1;
          if (t[k] < fl) begin
            s = t[k] / P;
            if (t[k] % P < CD && digit_en[s]) begin
              e.sel = 8'(1 << s);
              e.ctl = ac[k][s];
            end
          end
          e.fd = (t[k] == fl - 1);
          e.rdy = !pend[k];
        end
        q[k].push_back(e);
      end
    end
  end
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          a = {sel[k], ctl[k], fd[k], rdy[k]};
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL scan_u%0d @%0t: got sel=%h ctl=%h fd=%b rdy=%b, want sel=%h ctl=%h fd=%b rdy=%b",
                     (k == 0) ? 8 : 4, $time, a.sel, a.ctl, a.fd, a.rdy, e.sel, e.ctl, e.fd, e.rdy);
          end
        end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] dg, input logic [7:0] sg, input logic c);
    wr_valid = 1'b1;
    wr_digit = dg;
    wr_seg = sg;
    wr_commit = c;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_commit = 1'b0;
  endtask
  initial begin
    bit found;
    tick(3);
    rst = 1'b0;
    tick(1);
    wr(3'd0, 8'hFC, 1'b0);
    tick(100);
    wr(3'd1, 8'h60, 1'b0);
    wr(3'd0, 8'hFC, 1'b1);
    tick(120);
    digit_en = 8'hFE;
    tick(60);
    digit_en = 8'hFF;
    wr(3'd7, 8'hFF, 1'b1);
    tick(110);
    repeat (1500) begin
      wr_valid = ($urandom_range(3) == 0);
      wr_digit = 3'($urandom);
      wr_seg = 8'($urandom);
      wr_commit = ($urandom_range(40) == 0);
      digit_en = ($urandom_range(20) == 0) ? 8'($urandom) : 8'hFF;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_commit = 1'b0;
    digit_en = 8'hFF;
    wr(3'd2, 8'h9E, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++)
      if (t[0] == 8 * P) found = 1'b1;
      else tick(1);
    if (found) begin
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
    end else begin
      miscompares++;
      $display("FAIL swap_wait: got no swap cycle within 200 cycles, want one");
    end
    tick(110);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
